// File: rtl/vit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vit_pkg
//  Brief    : Shared types and constants for the Viterbi sequencing controller
//  Revision : 1.0 - initial release
// ============================================================================
package vit_pkg;

   // Default traceback window length / survivor memory depth
   localparam int VIT_DEPTH  = 8;

   // Width of the optional statistics counters
   localparam int VIT_STAT_W = 16;

   // Controller sequencing states
   typedef enum logic [1:0] {
      CLR = 2'd0,
      RUN = 2'd1,
      ACS = 2'd2,
      TB  = 2'd3
   } vit_ctrl_state_t;

endpackage : vit_pkg
`default_nettype wire

// File: rtl/vit_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vit_ctrl_if
//  Brief    : Received-symbol valid/ready handshake between symbol source
//             (master) and the Viterbi controller (slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface vit_ctrl_if;

   logic       rx_valid;
   logic       rx_ready;
   logic [1:0] rx_pair;
   logic       rx_last;

   modport master (
      output rx_valid,
      output rx_pair,
      output rx_last,
      input  rx_ready
   );

   modport slave (
      input  rx_valid,
      input  rx_pair,
      input  rx_last,
      output rx_ready
   );

endinterface : vit_ctrl_if
`default_nettype wire

// File: rtl/vit_tb_addr.sv
`default_nettype none
// ============================================================================
//  Module   : vit_tb_addr
//  Brief    : Traceback read address generator. Loads a start address and a
//             window length, then issues descending (mod DEPTH) survivor read
//             addresses for exactly that many cycles, flagging the final one.
//  Revision : 1.0 - initial release
// ============================================================================
module vit_tb_addr #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  wire logic          clk,
   input  wire logic          rst,       // asynchronous, active-low
   input  wire logic          load,
   input  wire logic [AW-1:0] start,
   input  wire logic [AW:0]   len,       // 1..DEPTH
   output logic               tb_en,
   output logic [AW-1:0]      tb_raddr,
   output logic               tb_last
);

   // Reads still to be issued, including the one currently presented
   logic [AW:0] remain;

   // Load / count-down of the traceback read sequence
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tb_en    <= 1'b0;
         tb_raddr <= '0;
         tb_last  <= 1'b0;
         remain   <= '0;
      end else if (load) begin
         tb_en    <= 1'b1;
         tb_raddr <= start;
         remain   <= len;
         tb_last  <= (len == (AW+1)'(1));
      end else if (tb_en) begin
         if (tb_last) begin
            tb_en   <= 1'b0;
            tb_last <= 1'b0;
         end else begin
            // Power-of-two depth makes the natural wrap 0 -> DEPTH-1 correct
            tb_raddr <= tb_raddr - 1'b1;
            remain   <= remain - 1'b1;
            tb_last  <= (remain == (AW+1)'(2));
         end
      end
   end

endmodule : vit_tb_addr
`default_nettype wire

// File: rtl/vit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vit_ctrl
//  Brief    : Sequencing controller for a rate-1/2 Viterbi decoder datapath.
//             Accepts symbol pairs, strobes ACS / survivor writes, and runs
//             block traceback at window-full or end of frame.
//  Config   : VIT_CTRL_STATS_EN - adds saturating stat_syms / stat_frames
//  Revision : 1.0 - initial release
// ============================================================================
module vit_ctrl
   import vit_pkg::*;
#(
   parameter  int DEPTH = VIT_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  wire logic       clk,
   input  wire logic       rst,          // asynchronous, active-low
   vit_ctrl_if.slave       rx,
   output logic [1:0]      bmc_pair,
   output logic            acs_en,
   output logic            pm_clr,
   output logic            sv_we,
   output logic [AW-1:0]   sv_waddr,
   output logic            tb_en,
   output logic [AW-1:0]   tb_raddr,
   output logic            tb_last,
   output logic            busy
`ifdef VIT_CTRL_STATS_EN
   ,
   output logic [VIT_STAT_W-1:0] stat_syms,
   output logic [VIT_STAT_W-1:0] stat_frames
`endif
);

   localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

   vit_ctrl_state_t state;
   logic [AW-1:0]   wptr;
   logic [AW:0]     cnt;
   logic            frame_end;

   logic            accept;
   logic [AW:0]     cnt_inc;
   logic            win_done;
   logic            tb_load;

   // Handshake, window-length and traceback-start decode
   always_comb begin
      accept   = rx.rx_valid & rx.rx_ready;
      cnt_inc  = cnt + 1'b1;
      win_done = (cnt_inc == LEN_FULL) | frame_end;
      tb_load  = (state == ACS) & win_done;
   end

   // Main sequencer; all outputs registered so they align with the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= CLR;
         wptr        <= '0;
         cnt         <= '0;
         frame_end   <= 1'b0;
         bmc_pair    <= '0;
         acs_en      <= 1'b0;
         pm_clr      <= 1'b0;
         sv_we       <= 1'b0;
         sv_waddr    <= '0;
         rx.rx_ready <= 1'b0;
         busy        <= 1'b0;
      end else begin
         acs_en <= 1'b0;
         sv_we  <= 1'b0;
         pm_clr <= 1'b0;
         case (state)
            CLR: begin
               wptr      <= '0;
               cnt       <= '0;
               frame_end <= 1'b0;
               // pm_clr doubles as the phase bit: coming out of reset it is
               // still low, so spend one cycle presenting the clear pulse.
               if (pm_clr) begin
                  state       <= RUN;
                  rx.rx_ready <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  pm_clr <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  bmc_pair    <= rx.rx_pair;
                  frame_end   <= rx.rx_last;
                  acs_en      <= 1'b1;
                  sv_we       <= 1'b1;
                  sv_waddr    <= wptr;
                  rx.rx_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= ACS;
               end
            end
            ACS: begin
               wptr <= wptr + 1'b1;
               cnt  <= cnt_inc;
               if (win_done) begin
                  state <= TB;
               end else begin
                  state       <= RUN;
                  rx.rx_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            TB: begin
               if (tb_last) begin
                  if (frame_end) begin
                     state  <= CLR;
                     pm_clr <= 1'b1;
                  end else begin
                     cnt         <= '0;
                     state       <= RUN;
                     rx.rx_ready <= 1'b1;
                     busy        <= 1'b0;
                  end
               end
            end
            default: state <= CLR;
         endcase
      end
   end

   // Traceback starts at the address just written (old wptr = new wptr - 1)
   vit_tb_addr #(
      .DEPTH (DEPTH)
   ) u_tb_addr (
      .clk      (clk),
      .rst      (rst),
      .load     (tb_load),
      .start    (wptr),
      .len      (cnt_inc),
      .tb_en    (tb_en),
      .tb_raddr (tb_raddr),
      .tb_last  (tb_last)
   );

`ifdef VIT_CTRL_STATS_EN
   // Saturating counts of accepted symbols and completed frames
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_syms   <= '0;
         stat_frames <= '0;
      end else begin
         if (accept && (stat_syms != '1))
            stat_syms <= stat_syms + 1'b1;
         if ((state == TB) && tb_last && frame_end && (stat_frames != '1))
            stat_frames <= stat_frames + 1'b1;
      end
   end
`endif

endmodule : vit_ctrl
`default_nettype wire

// File: tb/tb_vit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vit_ctrl
//  Brief    : Directed self-checking bench for vit_ctrl (DEPTH = 8)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vit_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    bmc_pair;
   logic          acs_en, pm_clr, sv_we, tb_en, tb_last, busy;
   logic [AW-1:0] sv_waddr, tb_raddr;
`ifdef VIT_CTRL_STATS_EN
   logic [15:0]   stat_syms, stat_frames;
`endif

   int checks = 0;
   int fails  = 0;

   vit_ctrl_if rx ();

   vit_ctrl #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .bmc_pair (bmc_pair),
      .acs_en   (acs_en),
      .pm_clr   (pm_clr),
      .sv_we    (sv_we),
      .sv_waddr (sv_waddr),
      .tb_en    (tb_en),
      .tb_raddr (tb_raddr),
      .tb_last  (tb_last),
      .busy     (busy)
`ifdef VIT_CTRL_STATS_EN
      ,
      .stat_syms   (stat_syms),
      .stat_frames (stat_frames)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one symbol once rx_ready is seen; returns in the ACS cycle
   task automatic send(input logic [1:0] p, input logic l);
      int k = 0;
      while (rx.rx_ready !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      checks++;
      if (rx.rx_ready !== 1'b1) begin
         fails++;
         $display("FAIL send_wait_ready: rx_ready=%b required 1", rx.rx_ready);
      end
      rx.rx_valid = 1'b1;
      rx.rx_pair  = p;
      rx.rx_last  = l;
      step();
      rx.rx_valid = 1'b0;
      rx.rx_last  = 1'b0;
   endtask

   // Pulse reset and land in the first RUN cycle
   task automatic do_reset();
      rx.rx_valid = 1'b0;
      rx.rx_last  = 1'b0;
      rst = 1'b0;
      step();
      #2 rst = 1'b1;
      step();
      step();
   endtask

   task automatic test_reset();
      rx.rx_valid = 1'b0;
      rx.rx_pair  = 2'b00;
      rx.rx_last  = 1'b0;
      #1 rst = 1'b0;
      step();
      step();
      checks++;
      if ({pm_clr, rx.rx_ready, acs_en, sv_we, tb_en, tb_last, busy} !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {pm_clr, rx.rx_ready, acs_en, sv_we, tb_en, tb_last, busy});
      end
      checks++;
      if ({bmc_pair, sv_waddr, tb_raddr} !== 8'h00) begin
         fails++;
         $display("FAIL reset_data: got %h required 00", {bmc_pair, sv_waddr, tb_raddr});
      end
      #2 rst = 1'b1;
      step();
      checks++;
      if ({pm_clr, rx.rx_ready, busy} !== 3'b101) begin
         fails++;
         $display("FAIL reset_clr_cycle: pm_clr/ready/busy=%b required 101",
                  {pm_clr, rx.rx_ready, busy});
      end
      step();
      checks++;
      if ({pm_clr, rx.rx_ready, busy} !== 3'b010) begin
         fails++;
         $display("FAIL reset_run_cycle: pm_clr/ready/busy=%b required 010",
                  {pm_clr, rx.rx_ready, busy});
      end
   endtask

   task automatic test_single();
      send(2'b10, 1'b0);
      checks++;
      if ({bmc_pair, acs_en, sv_we, sv_waddr, rx.rx_ready} !== 8'b10_1_1_000_0) begin
         fails++;
         $display("FAIL single_acs: pair/acs/we/waddr/ready=%b required 10110000",
                  {bmc_pair, acs_en, sv_we, sv_waddr, rx.rx_ready});
      end
      step();
      checks++;
      if ({bmc_pair, acs_en, rx.rx_ready, tb_en} !== 5'b10_0_1_0) begin
         fails++;
         $display("FAIL single_back_to_run: pair/acs/ready/tb_en=%b required 10010",
                  {bmc_pair, acs_en, rx.rx_ready, tb_en});
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ea;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         send(2'(i), 1'b0);
         ea = AW'(i);
         checks++;
         if ({acs_en, sv_we, sv_waddr, bmc_pair} !== {2'b11, ea, 2'(i)}) begin
            fails++;
            $display("FAIL b2b_write[%0d]: acs/we/waddr/pair=%b required %b",
                     i, {acs_en, sv_we, sv_waddr, bmc_pair}, {2'b11, ea, 2'(i)});
         end
      end
      step();
      for (int j = 0; j < DEPTH; j++) begin
         ea = AW'(DEPTH - 1 - j);
         checks++;
         if ({tb_en, tb_raddr, tb_last, busy} !== {1'b1, ea, (j == DEPTH - 1), 1'b1}) begin
            fails++;
            $display("FAIL b2b_tb[%0d]: en/raddr/last/busy=%b required %b",
                     j, {tb_en, tb_raddr, tb_last, busy}, {1'b1, ea, (j == DEPTH - 1), 1'b1});
         end
         step();
      end
      checks++;
      if ({rx.rx_ready, tb_en, busy, pm_clr} !== 4'b1000) begin
         fails++;
         $display("FAIL b2b_after_tb: ready/tb_en/busy/pm_clr=%b required 1000",
                  {rx.rx_ready, tb_en, busy, pm_clr});
      end
   endtask

   task automatic test_frame_end();
      logic [AW-1:0] ea;
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(2'b01, 1'b0);
      for (int j = 0; j <= DEPTH; j++) step();
      for (int i = 0; i < 3; i++) begin
         send(2'b11, (i == 2));
         ea = AW'(i);
         checks++;
         if (sv_waddr !== ea) begin
            fails++;
            $display("FAIL frame_write[%0d]: sv_waddr=%0d required %0d", i, sv_waddr, ea);
         end
      end
      step();
      for (int j = 0; j < 3; j++) begin
         ea = AW'(2 - j);
         checks++;
         if ({tb_en, tb_raddr, tb_last} !== {1'b1, ea, (j == 2)}) begin
            fails++;
            $display("FAIL frame_tb[%0d]: en/raddr/last=%b required %b",
                     j, {tb_en, tb_raddr, tb_last}, {1'b1, ea, (j == 2)});
         end
         step();
      end
      checks++;
      if ({pm_clr, rx.rx_ready, busy, tb_en} !== 4'b1010) begin
         fails++;
         $display("FAIL frame_clr: pm_clr/ready/busy/tb_en=%b required 1010",
                  {pm_clr, rx.rx_ready, busy, tb_en});
      end
      step();
      checks++;
      if ({pm_clr, rx.rx_ready} !== 2'b01) begin
         fails++;
         $display("FAIL frame_run: pm_clr/ready=%b required 01", {pm_clr, rx.rx_ready});
      end
   endtask

   task automatic test_last_ignored();
      logic [AW-1:0] ea;
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(2'b10, 1'b0);
      step();
      rx.rx_valid = 1'b1;
      rx.rx_pair  = 2'b11;
      rx.rx_last  = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
         checks++;
         if ({rx.rx_ready, acs_en} !== 2'b00) begin
            fails++;
            $display("FAIL ign_tb[%0d]: ready/acs=%b required 00", j, {rx.rx_ready, acs_en});
         end
         step();
      end
      rx.rx_last = 1'b0;
      step();
      rx.rx_valid = 1'b0;
      checks++;
      if ({acs_en, sv_waddr, bmc_pair} !== {1'b1, 3'd0, 2'b11}) begin
         fails++;
         $display("FAIL ign_accept: acs/waddr/pair=%b required 100011",
                  {acs_en, sv_waddr, bmc_pair});
      end
      step();
      checks++;
      if ({rx.rx_ready, tb_en, busy} !== 3'b100) begin
         fails++;
         $display("FAIL ign_no_frame_end: ready/tb_en/busy=%b required 100",
                  {rx.rx_ready, tb_en, busy});
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         send(2'b01, (i == DEPTH - 2));
         ea = AW'(i + 1);
         checks++;
         if (sv_waddr !== ea) begin
            fails++;
            $display("FAIL last8_write[%0d]: sv_waddr=%0d required %0d", i, sv_waddr, ea);
         end
      end
      step();
      for (int j = 0; j < DEPTH; j++) begin
         ea = AW'(DEPTH - 1 - j);
         checks++;
         if ({tb_en, tb_raddr, tb_last} !== {1'b1, ea, (j == DEPTH - 1)}) begin
            fails++;
            $display("FAIL last8_tb[%0d]: en/raddr/last=%b required %b",
                     j, {tb_en, tb_raddr, tb_last}, {1'b1, ea, (j == DEPTH - 1)});
         end
         step();
      end
      checks++;
      if ({pm_clr, rx.rx_ready} !== 2'b10) begin
         fails++;
         $display("FAIL last8_clr: pm_clr/ready=%b required 10", {pm_clr, rx.rx_ready});
      end
      step();
   endtask

   task automatic test_reset_mid_tb();
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(2'b00, 1'b0);
      step();
      step();
      step();
      step();
      checks++;
      if ({tb_en, tb_raddr} !== {1'b1, 3'd4}) begin
         fails++;
         $display("FAIL midtb_pre: en/raddr=%b required 1100", {tb_en, tb_raddr});
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({tb_en, tb_last, busy, acs_en, rx.rx_ready, tb_raddr} !== 8'h00) begin
         fails++;
         $display("FAIL midtb_async: en/last/busy/acs/ready/raddr=%b required 0",
                  {tb_en, tb_last, busy, acs_en, rx.rx_ready, tb_raddr});
      end
      step();
      #2 rst = 1'b1;
      step();
      checks++;
      if ({pm_clr, tb_en} !== 2'b10) begin
         fails++;
         $display("FAIL midtb_clr: pm_clr/tb_en=%b required 10", {pm_clr, tb_en});
      end
      send(2'b01, 1'b0);
      checks++;
      if ({acs_en, sv_waddr} !== {1'b1, 3'd0}) begin
         fails++;
         $display("FAIL midtb_wptr: acs/waddr=%b required 1000", {acs_en, sv_waddr});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_end();
      test_last_ignored();
      test_reset_mid_tb();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_vit_ctrl
`default_nettype wire
